// File: rtl/neuron_seq.sv
// Dot-product sequencer feeding an external integer MAC and returning its final sum on valid/ready.
// Optional NEURON_SEQ_BIAS_EN adds bias_i, latched at start and used as the empty-sum value.
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | accepting (value, weight) terms
//   DRAIN | MAC output settles, captured into res_o
//   DONE  | result offered until res_ready_i
module neuron_seq #(
  parameter int N = 16,
  parameter int K_MAX = 784,
  localparam int CW = $clog2(K_MAX + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [CW-1:0]   len_i,
`ifdef NEURON_SEQ_BIAS_EN
  input  logic [2*N-1:0]  bias_i,
`endif
  output logic            busy_o,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N-1:0]    value_i,
  input  logic [N-1:0]    weight_i,
  output logic            mac_en_o,
  output logic [N-1:0]    mac_value_o,
  output logic [N-1:0]    mac_mult_o,
  output logic [2*N-1:0]  mac_add_o,
  input  logic [2*N-1:0]  mac_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [2*N-1:0]  res_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] K_MAX_C = CW'(K_MAX);

  state_t          state_q, state_d;
  logic [CW-1:0]   remaining_q;
  logic            first_q;
  logic [2*N-1:0]  res_q;
  logic [CW-1:0]   len_c;
  logic            hs;
  logic [2*N-1:0]  empty_sum;
  logic [2*N-1:0]  empty_start;

`ifdef NEURON_SEQ_BIAS_EN
  logic [2*N-1:0]  bias_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bias_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      bias_q <= bias_i;
    end
  end

  assign empty_sum   = bias_q;
  assign empty_start = bias_i;
`else
  assign empty_sum   = '0;
  assign empty_start = '0;
`endif

  assign len_c = (len_i > K_MAX_C) ? K_MAX_C : len_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_o      = 1'b1;
    in_ready_o  = 1'b0;
    res_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = (len_c == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready_o = 1'b1;
        if (in_valid_i && remaining_q == CW'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign hs          = in_valid_i & in_ready_o;
  assign mac_en_o    = hs;
  assign mac_value_o = value_i;
  assign mac_mult_o  = weight_i;
  // Outside the first term the addend follows mac_i so the MAC inputs stay quiet while idle.
  assign mac_add_o   = first_q ? empty_sum : (busy_o ? mac_i : '0);
  assign res_o       = res_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remaining_q <= '0;
      first_q     <= 1'b0;
      res_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            remaining_q <= len_c;
            first_q     <= (len_c != '0);
            if (len_c == '0) begin
              res_q <= empty_start;
            end
          end
        end
        RUN: begin
          if (hs) begin
            remaining_q <= remaining_q - CW'(1);
            first_q     <= 1'b0;
          end
        end
        DRAIN: begin
          res_q <= mac_i;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq.sv
// Self-checking bench for neuron_seq (N=8) with a behavioural MAC and a sum-of-products reference.
module tb_neuron_seq;

  localparam int N = 8;
  localparam int K_MAX = 784;
  localparam int CW = $clog2(K_MAX + 1);

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic [CW-1:0]   len_i = '0;
  logic [2*N-1:0]  bias_i = '0;
  logic            busy_o;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [N-1:0]    value_i = '0;
  logic [N-1:0]    weight_i = '0;
  logic            mac_en_o;
  logic [N-1:0]    mac_value_o;
  logic [N-1:0]    mac_mult_o;
  logic [2*N-1:0]  mac_add_o;
  logic [2*N-1:0]  mac_i;
  logic            res_valid_o;
  logic            res_ready_i = 1'b0;
  logic [2*N-1:0]  res_o;

  int n_err = 0;
  int n_chk = 0;
  int en_cnt = 0;
  logic preload = 1'b0;
  logic [2*N-1:0] mac_q = '0;
  logic [N-1:0] va [0:K_MAX+7];
  logic [N-1:0] wa [0:K_MAX+7];
  logic [2*N-1:0] bias_v = '0;

  always #5 clk_i = ~clk_i;

  neuron_seq #(.N(N), .K_MAX(K_MAX)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .len_i       (len_i),
`ifdef NEURON_SEQ_BIAS_EN
    .bias_i      (bias_i),
`endif
    .busy_o      (busy_o),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .value_i     (value_i),
    .weight_i    (weight_i),
    .mac_en_o    (mac_en_o),
    .mac_value_o (mac_value_o),
    .mac_mult_o  (mac_mult_o),
    .mac_add_o   (mac_add_o),
    .mac_i       (mac_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_o       (res_o)
  );

  // Behavioural MAC: registered multiply-accumulate, wraps modulo 2^(2N).
  always @(posedge clk_i) begin
    if (preload) mac_q <= 16'hBEEF;
    else if (mac_en_o) mac_q <= 16'(16'(mac_value_o) * 16'(mac_mult_o) + mac_add_o);
    if (mac_en_o) en_cnt <= en_cnt + 1;
  end
  assign mac_i = mac_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*N-1:0] ref_dot(input int len);
    int k;
    logic [2*N-1:0] acc;
    k = (len > K_MAX) ? K_MAX : len;
    acc = bias_v;
    for (int i = 0; i < k; i++) acc = acc + 16'(int'(va[i]) * int'(wa[i]));
    return acc;
  endfunction

  // gap_mode: 0 = every cycle, 1 = two idle cycles before each later term, 2 = random 0..2 gaps.
  task automatic run_dot(input int len, input int gap_mode, input int hold, input bit pre);
    int k;
    int en0;
    int ng;
    logic [2*N-1:0] exp;
    k = (len > K_MAX) ? K_MAX : len;
    exp = ref_dot(len);
    if (pre) begin
      @(negedge clk_i); preload = 1'b1;
      @(negedge clk_i); preload = 1'b0;
    end
    @(negedge clk_i);
    start_i = 1'b1; len_i = CW'(len); bias_i = bias_v;
    @(negedge clk_i);
    start_i = 1'b0; len_i = '0; bias_i = '0;
    en0 = en_cnt;
    #1;
    chk("busy_after_start", busy_o, 1'b1);
    if (k == 0) begin
      chk("len0_valid", res_valid_o, 1'b1);
      chk("len0_res", res_o, exp);
      chk("len0_ready", in_ready_o, 1'b0);
    end else begin
      chk("ready_after_start", in_ready_o, 1'b1);
      for (int i = 0; i < k; i++) begin
        ng = (gap_mode == 1 && i > 0) ? 2 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
        for (int g = 0; g < ng; g++) begin
          in_valid_i = 1'b0; value_i = N'($urandom); weight_i = N'($urandom);
          #1;
          chk("gap_no_en", mac_en_o, 1'b0);
          @(negedge clk_i);
        end
        in_valid_i = 1'b1; value_i = va[i]; weight_i = wa[i];
        #1;
        chk("term_en", mac_en_o, 1'b1);
        chk("term_val", mac_value_o, va[i]);
        chk("term_mult", mac_mult_o, wa[i]);
        if (i == 0) chk("first_addend", mac_add_o, bias_v);
        @(negedge clk_i);
      end
      in_valid_i = 1'b0;
      #1;
      chk("drain_ready", in_ready_o, 1'b0);
      chk("drain_valid", res_valid_o, 1'b0);
      @(negedge clk_i);
      #1;
      chk("res_valid", res_valid_o, 1'b1);
      chk("res_value", res_o, exp);
    end
    for (int h = 0; h < hold; h++) begin
      start_i = h[0]; len_i = CW'(1);
      #1;
      chk("hold_valid", res_valid_o, 1'b1);
      chk("hold_res", res_o, exp);
      @(negedge clk_i);
    end
    res_ready_i = 1'b1; start_i = 1'b1; len_i = CW'(1);
    @(negedge clk_i);
    res_ready_i = 1'b0; start_i = 1'b0; len_i = '0;
    #1;
    chk("valid_one_cycle", res_valid_o, 1'b0);
    chk("idle_after_accept", busy_o, 1'b0);
    chk("en_count", en_cnt - en0, k);
  endtask

  task automatic new_bias();
`ifdef NEURON_SEQ_BIAS_EN
    bias_v = 16'($urandom);
`else
    bias_v = '0;
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", in_ready_o, 1'b0);
    chk("rst_en", mac_en_o, 1'b0);
    chk("rst_valid", res_valid_o, 1'b0);
    chk("rst_res", res_o, '0);
    chk("rst_add", mac_add_o, '0);
    rst_ni = 1'b1;

    va[0] = 8'd2; wa[0] = 8'd3;
    va[1] = 8'd4; wa[1] = 8'd5;
    va[2] = 8'd1; wa[2] = 8'd10;
`ifdef NEURON_SEQ_BIAS_EN
    bias_v = 16'h0100;
`endif
    chk("ref_basic", ref_dot(3), 16'd36 + bias_v);
    run_dot(3, 0, 0, 1'b0);
    run_dot(3, 1, 0, 1'b1);
    run_dot(0, 0, 0, 1'b0);

    va[0] = 8'd255; wa[0] = 8'd255;
    va[1] = 8'd255; wa[1] = 8'd255;
    chk("ref_wrap", ref_dot(2), 16'hFC02 + bias_v);
    run_dot(2, 0, 5, 1'b0);

    // Abort after one of three terms; a fresh operation must be unaffected.
    va[0] = 8'd9; wa[0] = 8'd9;
    @(negedge clk_i);
    start_i = 1'b1; len_i = CW'(3); bias_i = bias_v;
    @(negedge clk_i);
    start_i = 1'b0;
    in_valid_i = 1'b1; value_i = va[0]; weight_i = wa[0];
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_ready", in_ready_o, 1'b0);
    chk("abort_valid", res_valid_o, 1'b0);
    chk("abort_res", res_o, '0);
    chk("abort_add", mac_add_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    va[0] = 8'd7; wa[0] = 8'd6;
    new_bias();
    chk("ref_after_abort", ref_dot(1), 16'd42 + bias_v);
    run_dot(1, 0, 0, 1'b1);

    for (int i = 0; i < K_MAX + 5; i++) begin
      va[i] = 8'd1; wa[i] = 8'd1;
    end
    new_bias();
    chk("ref_clamp", ref_dot(K_MAX + 5), 16'(K_MAX) + bias_v);
    run_dot(K_MAX + 5, 0, 0, 1'b0);

    for (int r = 0; r < 15; r++) begin
      int len;
      len = (r % 5 == 4) ? 0 : int'($urandom_range(1, 12));
      for (int i = 0; i < 12; i++) begin
        va[i] = N'($urandom); wa[i] = N'($urandom);
      end
      new_bias();
      run_dot(len, 2, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
